// File: rtl/tmds_decode_if.sv
// Bus bundle for tmds_decode: raw deserialized word in, lock status and decoded symbol out.
// lock_loss_cnt exists only when TMDS_LOCK_LOSS_CNT_EN is defined.
interface tmds_decode_if;
  logic [9:0] data_in;
  logic       aligned;
  logic [3:0] offset;
  logic       de;
  logic       c0;
  logic       c1;
  logic [7:0] data_out;
`ifdef TMDS_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  // master: the deserializer side feeding words and watching the decode
  modport master (
    output data_in,
`ifdef TMDS_LOCK_LOSS_CNT_EN
    input  lock_loss_cnt,
`endif
    input  aligned, offset, de, c0, c1, data_out
  );

  modport slave (
    input  data_in,
`ifdef TMDS_LOCK_LOSS_CNT_EN
    output lock_loss_cnt,
`endif
    output aligned, offset, de, c0, c1, data_out
  );
endinterface

// File: rtl/tmds_decode.sv
// Single-channel TMDS receive decoder: bit-rotation word alignment on control-token runs,
// then token / 8b pixel decode. Optional macro TMDS_LOCK_LOSS_CNT_EN adds lock_loss_cnt.
module tmds_decode #(
  parameter int CTRL_CNT_MIN = 16,
  parameter int SEARCH_WIN   = 2048
) (
  input logic          sys_clk,
  input logic          sys_rst,
  tmds_decode_if.slave bus
);
  localparam int NUM_ROT      = 10;
  localparam int FLUSH_STAGES = 2;
  localparam int RUN_W        = $clog2(CTRL_CNT_MIN + 1);
  localparam int WD_W         = $clog2(SEARCH_WIN);

  localparam logic [RUN_W-1:0] RUN_QUAL = RUN_W'(CTRL_CNT_MIN - 1);
  localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(CTRL_CNT_MIN);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(SEARCH_WIN - 1);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic       de;
    logic       c1;
    logic       c0;
    logic [7:0] data;
  } sym_t;

  state_e                  state, state_nxt;
  logic [9:0]              data_d;
  logic [9:0]              word_r;
  logic [9:0]              rot_word;
  logic [19:0]             win;
  logic [9:0]              cand [NUM_ROT];
  logic [3:0]              offset_r;
  logic [RUN_W-1:0]        run_cnt;
  logic [WD_W-1:0]         wd_cnt;
  logic [FLUSH_STAGES-1:0] flush_pipe;
  logic                    is_tok;
  logic [1:0]              tok_c;
  logic [7:0]              d;
  logic [7:0]              dec_byte;
  logic                    flush;
  logic                    tok_hit;
  logic                    qualify;
  logic                    expire;
  logic                    lock_loss;
  sym_t                    sym_r, sym_nxt;

  // Older word sits in the low half so offset k picks serial bits k..k+9 of the pair
  assign win = {bus.data_in, data_d};

  for (genvar k = 0; k < NUM_ROT; k++) begin : g_rot
    assign cand[k] = win[k +: 10];
  end

  always_comb begin
    rot_word = cand[0];
    for (int k = 1; k < NUM_ROT; k++) begin
      if (offset_r == 4'(k)) rot_word = cand[k];
    end
  end

  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    unique case (word_r)
      TOK_00:  tok_c = 2'b00;
      TOK_01:  tok_c = 2'b01;
      TOK_10:  tok_c = 2'b10;
      TOK_11:  tok_c = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Undo the optional DC-balance inversion, then the XOR/XNOR transition chain
  assign d           = word_r[9] ? ~word_r[7:0] : word_r[7:0];
  assign dec_byte[0] = d[0];
  for (genvar i = 1; i < 8; i++) begin : g_dec
    assign dec_byte[i] = word_r[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
  end

  // Window contents right after a slip mix two rotations; ignore tokens until they drain
  assign flush     = |flush_pipe;
  assign tok_hit   = is_tok && !flush;
  assign qualify   = tok_hit && (run_cnt == RUN_QUAL);
  assign expire    = (wd_cnt == WD_LAST) && !qualify;
  assign lock_loss = (state == LOCKED) && expire;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= SEARCH;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SEARCH: if (qualify) state_nxt = LOCKED;
      LOCKED: if (expire)  state_nxt = SEARCH;
      default:             state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    sym_nxt = '0;
    if (state == LOCKED) begin
      if (is_tok) begin
        sym_nxt.c1 = tok_c[1];
        sym_nxt.c0 = tok_c[0];
      end else begin
        sym_nxt.de   = 1'b1;
        sym_nxt.c1   = sym_r.c1;
        sym_nxt.c0   = sym_r.c0;
        sym_nxt.data = dec_byte;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      data_d     <= '0;
      word_r     <= '0;
      offset_r   <= '0;
      run_cnt    <= '0;
      wd_cnt     <= '0;
      flush_pipe <= '0;
      sym_r      <= '0;
    end else begin
      data_d     <= bus.data_in;
      word_r     <= rot_word;
      sym_r      <= sym_nxt;
      flush_pipe <= {flush_pipe[FLUSH_STAGES-2:0], expire};

      if (expire) begin
        offset_r <= (offset_r == 4'd9) ? 4'd0 : offset_r + 4'd1;
        wd_cnt   <= '0;
        run_cnt  <= '0;
      end else begin
        wd_cnt <= qualify ? '0 : wd_cnt + WD_W'(1);
        if (!tok_hit)               run_cnt <= '0;
        else if (run_cnt != RUN_SAT) run_cnt <= run_cnt + RUN_W'(1);
      end
    end
  end

`ifdef TMDS_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)                            loss_cnt <= '0;
    else if (lock_loss && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
  end

  assign bus.lock_loss_cnt = loss_cnt;
`else
  logic unused_lock_loss;
  assign unused_lock_loss = lock_loss;
`endif

  assign bus.aligned  = (state == LOCKED);
  assign bus.offset   = offset_r;
  assign bus.de       = sym_r.de;
  assign bus.c1       = sym_r.c1;
  assign bus.c0       = sym_r.c0;
  assign bus.data_out = sym_r.data;
endmodule

// File: tb/tb_tmds_decode.sv
// Randomized bench for tmds_decode: serial bit-stream generator with arbitrary delay,
// a reference TMDS encoder for pixel symbols, and a symbol-level output model.
module tb_tmds_decode;
  localparam int CTRL_CNT_MIN = 16;
  localparam int SEARCH_WIN   = 2048;
  localparam int LINE_LEN     = 800;
  localparam int LINE_TOK     = 160;

  typedef struct packed {
    logic       de;
    logic       c1;
    logic       c0;
    logic [7:0] d;
  } obs_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  tmds_decode_if bus ();

  tmds_decode #(.CTRL_CNT_MIN(CTRL_CNT_MIN), .SEARCH_WIN(SEARCH_WIN)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         slips    = 0;
  logic [3:0] prev_off = 4'd0;
  int         slip_cyc[$];
  bit         sq[$];

  function automatic logic [9:0] tok_word(input int i);
    case (i)
      0:       return 10'b1101010100;
      1:       return 10'b0010101011;
      2:       return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic int tok_index(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == tok_word(i)) return i;
    return -1;
  endfunction

  // Standard TMDS transmit stage 1 plus an arbitrary choice of DC-balance inversion
  function automatic logic [9:0] tmds_enc(input logic [7:0] b, input bit inv);
    int         ones;
    bit         use_xnor;
    logic [8:0] qm;
    ones     = $countones(b);
    use_xnor = (ones > 4) || (ones == 4 && b[0] == 1'b0);
    qm[0]    = b[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
    qm[8] = ~use_xnor;
    return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm};
  endfunction

  task automatic gen_data(output logic [9:0] w, output logic [7:0] b);
    b = 8'($urandom_range(0, 255));
    w = tmds_enc(b, 1'($urandom_range(0, 1)));
    if (tok_index(w) >= 0) begin
      b = 8'h00;
      w = 10'h100;
    end
  endtask

  task automatic tick(input logic [9:0] w);
    bus.data_in = w;
    @(posedge sys_clk);
    #1;
    cyc++;
    if (bus.offset !== prev_off) begin
      slips++;
      slip_cyc.push_back(cyc);
    end
    prev_off = bus.offset;
  endtask

  // Serializes a symbol LSB-first into the bit stream; emits one word per full 10 bits
  task automatic push_sym(input logic [9:0] s);
    logic [9:0] w;
    for (int b = 0; b < 10; b++) sq.push_back(s[b]);
    if (sq.size() >= 10) begin
      for (int b = 0; b < 10; b++) w[b] = sq.pop_front();
      tick(w);
    end
  endtask

  task automatic do_reset();
    sys_rst     = 1'b1;
    bus.data_in = 10'($urandom);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst  = 1'b0;
    cyc      = 0;
    slips    = 0;
    prev_off = 4'd0;
    sq.delete();
    slip_cyc.delete();
  endtask

  task automatic test_reset();
    logic [15:0] act;
    sys_rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) sys_rst = 1'b0;
      bus.data_in = 10'($urandom);
      @(posedge sys_clk);
      #1;
      act = {bus.aligned, bus.offset, bus.de, bus.c0, bus.c1, bus.data_out};
      checks++;
      if (act !== 16'h0) begin
        failures++;
        $display("FAIL reset[%0d]: got %h expected 0000", i, act);
      end
`ifdef TMDS_LOCK_LOSS_CNT_EN
      checks++;
      if (bus.lock_loss_cnt !== 8'd0) begin
        failures++;
        $display("FAIL reset_loss_cnt[%0d]: got %0d expected 0", i, bus.lock_loss_cnt);
      end
`endif
    end
  endtask

  task automatic test_lock_offset0();
    logic [9:0] w;
    logic [7:0] b;
    int         lock_cyc = -1;
    do_reset();
    for (int ln = 0; ln < 3; ln++) begin
      for (int s = 0; s < LINE_LEN; s++) begin
        if (s < LINE_TOK) w = tok_word(0);
        else gen_data(w, b);
        push_sym(w);
        if (lock_cyc < 0 && bus.aligned === 1'b1) lock_cyc = cyc;
      end
    end
    checks++;
    if (lock_cyc !== CTRL_CNT_MIN + 2) begin
      failures++;
      $display("FAIL lock0_time: got cycle %0d expected %0d", lock_cyc, CTRL_CNT_MIN + 2);
    end
    checks++;
    if (bus.offset !== 4'd0 || slips !== 0) begin
      failures++;
      $display("FAIL lock0_offset: got offset %0d slips %0d expected 0/0", bus.offset, slips);
    end
    checks++;
    if (bus.aligned !== 1'b1) begin
      failures++;
      $display("FAIL lock0_hold: got aligned %b expected 1", bus.aligned);
    end
  endtask

  task automatic test_misaligned();
    logic [9:0] w;
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 3; i++) sq.push_back(1'($urandom_range(0, 1)));
    for (int ln = 0; ln < 10 && bus.aligned !== 1'b1; ln++) begin
      for (int s = 0; s < LINE_LEN; s++) begin
        if (s < LINE_TOK) w = tok_word(0);
        else gen_data(w, b);
        push_sym(w);
      end
    end
    checks++;
    if (slips !== 3) begin
      failures++;
      $display("FAIL misalign_slips: got %0d expected 3", slips);
    end
    for (int i = 0; i < 3 && i < slip_cyc.size(); i++) begin
      checks++;
      if (slip_cyc[i] !== SEARCH_WIN * (i + 1)) begin
        failures++;
        $display("FAIL misalign_slip_time[%0d]: got cycle %0d expected %0d",
                 i, slip_cyc[i], SEARCH_WIN * (i + 1));
      end
    end
    checks++;
    if (bus.aligned !== 1'b1 || bus.offset !== 4'd3) begin
      failures++;
      $display("FAIL misalign_lock: got aligned %b offset %0d expected 1/3",
               bus.aligned, bus.offset);
    end
  endtask

  task automatic test_decode();
    logic [9:0] w;
    logic [7:0] b;
    logic [1:0] c_model = 2'b00;
    obs_t       e, act;
    obs_t       exp_q[$];
    int         t;
    do_reset();
    for (int i = 0; i < 40; i++) push_sym(tok_word(0));
    checks++;
    if (bus.aligned !== 1'b1) begin
      failures++;
      $display("FAIL decode_prelock: got aligned %b expected 1", bus.aligned);
    end
    for (int ln = 0; ln < 4; ln++) begin
      for (int s = 0; s < 172; s++) begin
        b = 8'h00;
        if (s < 20) w = tok_word(0);
        else if (ln == 0 && s == 20) begin w = 10'h100; b = 8'h00; end
        else if (ln == 0 && s == 21) begin w = 10'h200; b = 8'hFF; end
        else if ($urandom_range(0, 7) == 0) w = tok_word(int'($urandom_range(0, 3)));
        else gen_data(w, b);
        t = tok_index(w);
        if (t >= 0) begin
          c_model = 2'(t);
          e = '{de: 1'b0, c1: c_model[1], c0: c_model[0], d: 8'h00};
        end else begin
          e = '{de: 1'b1, c1: c_model[1], c0: c_model[0], d: b};
        end
        exp_q.push_back(e);
        push_sym(w);
        if (exp_q.size() == 3) begin
          e   = exp_q.pop_front();
          act = {bus.de, bus.c1, bus.c0, bus.data_out};
          checks++;
          if (act !== e) begin
            failures++;
            $display("FAIL decode[%0d.%0d]: got de=%b c=%b%b d=%h expected de=%b c=%b%b d=%h",
                     ln, s, act.de, act.c1, act.c0, act.d, e.de, e.c1, e.c0, e.d);
          end
        end
      end
    end
  endtask

  task automatic test_control();
    logic [9:0] w;
    logic [7:0] b;
    logic [1:0] c_model = 2'b00;
    obs_t       e, act;
    obs_t       exp_q[$];
    for (int s = 0; s < 10; s++) begin
      if (s < 8 && s[0] == 1'b0) begin
        w = tok_word(s / 2);
        c_model = 2'(s / 2);
        e = '{de: 1'b0, c1: c_model[1], c0: c_model[0], d: 8'h00};
      end else begin
        gen_data(w, b);
        e = '{de: 1'b1, c1: c_model[1], c0: c_model[0], d: b};
      end
      exp_q.push_back(e);
      push_sym(w);
      if (exp_q.size() == 3) begin
        e   = exp_q.pop_front();
        act = {bus.de, bus.c1, bus.c0, bus.data_out};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL control[%0d]: got de=%b c=%b%b d=%h expected de=%b c=%b%b d=%h",
                   s - 2, act.de, act.c1, act.c0, act.d, e.de, e.c1, e.c0, e.d);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    logic [9:0] w;
    logic [7:0] b;
    int         fall = -1;
    logic [3:0] off_at_fall = 4'd0;
`ifdef TMDS_LOCK_LOSS_CNT_EN
    logic [7:0] loss_at_fall = 8'd0;
`endif
    for (int i = 0; i < 2200 && fall < 0; i++) begin
      if (i < 20) w = tok_word(0);
      else gen_data(w, b);
      push_sym(w);
      if (bus.aligned !== 1'b1) begin
        fall        = i + 1;
        off_at_fall = bus.offset;
`ifdef TMDS_LOCK_LOSS_CNT_EN
        loss_at_fall = bus.lock_loss_cnt;
`endif
      end
    end
    checks++;
    if (fall !== CTRL_CNT_MIN + 2 + SEARCH_WIN) begin
      failures++;
      $display("FAIL lockloss_time: got symbol %0d expected %0d",
               fall, CTRL_CNT_MIN + 2 + SEARCH_WIN);
    end
    checks++;
    if (off_at_fall !== 4'd1) begin
      failures++;
      $display("FAIL lockloss_offset: got %0d expected 1", off_at_fall);
    end
`ifdef TMDS_LOCK_LOSS_CNT_EN
    checks++;
    if (loss_at_fall !== 8'd1) begin
      failures++;
      $display("FAIL lockloss_cnt: got %0d expected 1", loss_at_fall);
    end
`endif
  endtask

  initial begin
    bus.data_in = 10'h000;
    test_reset();
    test_lock_offset0();
    test_misaligned();
    test_decode();
    test_control();
    test_lock_loss();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tmds_decode.md
Name: tmds_decode

Overview:
- Receive-side counterpart of the HDMI TMDS transmit path for one TMDS channel (R, G or B).
- Takes raw 10-bit parallel words from an upstream deserializer clocked at sys_clk. The deserializer's word boundary is arbitrary.
- Finds symbol alignment by hunting for runs of control tokens, using an internal 0..9 bit rotation.
- Once aligned, decodes each symbol into de, c0 (hsync), c1 (vsync) and 8-bit pixel data.

Parameters:
- CTRL_CNT_MIN, 16: consecutive control tokens needed to qualify a blanking run (range 2..255).
- SEARCH_WIN, 2048: watchdog length in cycles; a qualifying run must occur within this window. Must exceed one video line period.

Ports:
- sys_clk  in  1  pixel clock; one clock; all logic on rising edge.
- sys_rst  in  1  reset; reset is synchronous and active-high.
- data_in  in  10  raw deserialized word; bit 0 is the earliest serial bit.
- aligned  out  1  1 = symbol lock achieved.
- offset  out  4  current rotation offset, 0..9.
- de  out  1  data enable (pixel symbol).
- c0  out  1  decoded control bit 0 (hsync).
- c1  out  1  decoded control bit 1 (vsync).
- data_out  out  8  decoded pixel byte.

Behaviour:
- Reset (sys_rst=1 at an edge):
  - aligned, de, c0, c1, data_out = 0; offset = 0; state = SEARCH.
  - All counters and pipeline registers clear.
  - Reset mid-lock behaves identically; no state is retained.
- Pipeline:
  - S0: data_d <= data_in.
  - S1: word_r <= {data_in, data_d}[offset+9 : offset].
  - S2: output registers.
  - At fixed offset, a word sampled into data_d at edge N drives the outputs after edge N+2.
- Token detection on word_r:
  - 10'b1101010100 -> {c1,c0} = 00.
  - 10'b0010101011 -> 01.
  - 10'b0101010100 -> 10.
  - 10'b1010101011 -> 11.
  - Any other word is a data symbol.
- Data decode:
  - d = word_r[9] ? ~word_r[7:0] : word_r[7:0].
  - out[0] = d[0].
  - For i = 1..7: out[i] = word_r[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Output rule (S2), while aligned = 1:
  - Token: de = 0, {c1,c0} from the token, data_out = 0.
  - Data symbol: de = 1, c0/c1 hold their previous values, data_out = decoded byte.
- Output rule while aligned = 0: de = c0 = c1 = 0, data_out = 0.
- run_cnt:
  - Increments on each token; saturates at CTRL_CNT_MIN.
  - Clears on any data symbol.
- Qualify event: the cycle run_cnt goes from CTRL_CNT_MIN-1 to CTRL_CNT_MIN.
- wd_cnt:
  - Increments every cycle.
  - Clears on a qualify event (qualify wins over expiry in the same cycle).
  - Expiry = wd_cnt == SEARCH_WIN-1.
- Slip:
  - offset <= (offset == 9) ? 0 : offset + 1.
  - wd_cnt and run_cnt clear.
  - Token counting is suppressed for the 2 cycles following a slip, to flush stale window data.
- FSM:
  - SEARCH: a qualify event -> LOCKED, and aligned = 1 from the next edge. An expiry -> slip, stay in SEARCH.
  - LOCKED: a qualify event -> wd_cnt clears, stay in LOCKED. An expiry -> SEARCH, aligned = 0 at the same edge, plus a slip.
- Offset wrap: offset 9 slips to 0. With a fixed input bit delay k (0..9), lock settles at offset = k.

Optional Feature:
- Macro TMDS_LOCK_LOSS_CNT_EN.
- Defined:
  - Adds output port lock_loss_cnt, out, 8.
  - Resets to 0.
  - Increments on every LOCKED -> SEARCH transition.
  - Saturates at 255.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold sys_rst = 1 for 5 cycles with random data_in -> aligned = 0, offset = 0, de = c0 = c1 = 0, data_out = 0 throughout and for 2 cycles after release.
- Lock at offset 0: 800-symbol lines, 160 tokens 1101010100 then 640 data symbols, with SEARCH_WIN = 2048 -> aligned rises 1 cycle after the 16th token reaches word_r. offset stays 0; no slips occur.
- Misaligned stream: the same stream delayed by 3 bits -> exactly 3 slips occur, each at wd_cnt expiry. Lock is then reached with offset = 3 and aligned = 1.
- Data decode, locked at offset 0: input 10'h100 -> de = 1, data_out = 8'h00. Input 10'h200 -> data_out = 8'hFF. Both appear 2 cycles after capture.
- Control decode: each of the 4 tokens in turn -> de = 0 with {c1,c0} = 00, 01, 10, 11 respectively. c0/c1 hold their values across a following data symbol.
- Lock loss: after lock, feed 2048 consecutive data symbols -> aligned falls at expiry and offset goes 0 -> 1. With TMDS_LOCK_LOSS_CNT_EN defined, lock_loss_cnt goes 0 -> 1.
